warp_issue_scheduler: RTL

//  Controller for NUM_WARPS per-warp instruction_fifo instances. Round-robin selects one ready warp per cycle,

---
 rtl/warp_issue_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: round-robin issue from per-warp instruction FIFOs to a
// registered valid/ready issue port, plus round-robin instruction-fetch refill requests.
//
// state | meaning
// IDLE  | no pops, no new fetch requests; outstanding fetch_done still retires
// RUN   | issue arbiter and fetch arbiter active
// DRAIN | wait for the held issue to be accepted, then IDLE
module warp_issue_scheduler #(
  parameter int NUM_WARPS  = 4,
  parameter int DATA_WIDTH = 32,
  localparam int WID_W     = $clog2(NUM_WARPS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sched_en,
  input  logic                            flush,
  input  logic [NUM_WARPS-1:0]            warp_active,
  input  logic [NUM_WARPS-1:0]            warp_stall,
  input  logic [NUM_WARPS-1:0]            fifo_valid,
  input  logic [NUM_WARPS-1:0]            fifo_full,
  input  logic [NUM_WARPS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_WARPS-1:0]            fifo_pop,
  output logic                            issue_valid,
  input  logic                            issue_ready,
  output logic [DATA_WIDTH-1:0]           issue_instr,
  output logic [WID_W-1:0]                issue_warp_id,
  output logic                            fetch_req_valid,
  input  logic                            fetch_req_ready,
  output logic [WID_W-1:0]                fetch_warp_id,
  input  logic                            fetch_done,
  input  logic [WID_W-1:0]                fetch_done_id,
  output logic                            sched_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic [WID_W-1:0] PTR_RST = WID_W'(NUM_WARPS - 1);

  state_t state, state_nxt;

  logic [WID_W-1:0]     issue_ptr;
  logic [WID_W-1:0]     fetch_ptr;
  logic [NUM_WARPS-1:0] pending;
  logic [NUM_WARPS-1:0] pending_nxt;

  logic [NUM_WARPS-1:0]  cand;
  logic [NUM_WARPS-1:0]  fcand;
  logic [NUM_WARPS-1:0]  acc_mask;
  logic [WID_W-1:0]      issue_gnt;
  logic [WID_W-1:0]      fetch_gnt;
  logic                  issue_load;
  logic                  issue_go;
  logic                  fetch_load;
  logic                  fetch_acc;
  logic [DATA_WIDTH-1:0] fifo_words [NUM_WARPS];

  // First requester strictly after ptr, wrapping; ptr itself has lowest priority.
  function automatic logic [WID_W-1:0] rr_pick(input logic [NUM_WARPS-1:0] req,
                                               input logic [WID_W-1:0]     ptr);
    logic [WID_W-1:0] g;
    logic [WID_W-1:0] idx_w;
    logic             found;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_WARPS) idx = idx - NUM_WARPS;
      idx_w = WID_W'(idx);
      if (!found && req[idx_w]) begin
        found = 1'b1;
        g     = idx_w;
      end
    end
    return g;
  endfunction

  function automatic logic [NUM_WARPS-1:0] onehot(input logic [WID_W-1:0] id);
    logic [NUM_WARPS-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      fifo_words[w] = fifo_data[w*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sched_en) state_nxt = ST_RUN;
      ST_RUN:   if (!sched_en) state_nxt = (issue_valid && !issue_ready) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (!issue_valid || issue_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  assign sched_busy = (state != ST_IDLE);

  // Issue arbiter
  assign cand       = warp_active & fifo_valid & ~warp_stall;
  assign issue_load = !issue_valid || issue_ready;
  assign issue_go   = (state == ST_RUN) && issue_load && (|cand) && !flush;
  assign issue_gnt  = rr_pick(cand, issue_ptr);
  assign fifo_pop   = issue_go ? onehot(issue_gnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid   <= 1'b0;
      issue_instr   <= '0;
      issue_warp_id <= '0;
      issue_ptr     <= PTR_RST;
    end else if (flush) begin
      issue_valid <= 1'b0;
      issue_ptr   <= PTR_RST;
    end else if (issue_load) begin
      if (issue_go) begin
        issue_valid   <= 1'b1;
        issue_instr   <= fifo_words[issue_gnt];
        issue_warp_id <= issue_gnt;
        issue_ptr     <= issue_gnt;
      end else begin
        issue_valid <= 1'b0;
      end
    end
  end

  // Fetch arbiter; the warp being accepted this cycle is masked so it is not re-requested
  assign fetch_acc  = fetch_req_valid && fetch_req_ready;
  assign acc_mask   = fetch_acc ? onehot(fetch_warp_id) : '0;
  assign fcand      = warp_active & ~fifo_full & ~pending & ~acc_mask;
  assign fetch_load = !fetch_req_valid || fetch_req_ready;
  assign fetch_gnt  = rr_pick(fcand, fetch_ptr);

  always_comb begin
    pending_nxt = pending | acc_mask;
    if (fetch_done) pending_nxt[fetch_done_id] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_req_valid <= 1'b0;
      fetch_warp_id   <= '0;
      fetch_ptr       <= PTR_RST;
      pending         <= '0;
    end else if (flush) begin
      fetch_req_valid <= 1'b0;
      fetch_ptr       <= PTR_RST;
      pending         <= '0;
    end else begin
      if (fetch_load) begin
        if ((state != ST_IDLE) && (|fcand)) begin
          fetch_req_valid <= 1'b1;
          fetch_warp_id   <= fetch_gnt;
        end else begin
          fetch_req_valid <= 1'b0;
        end
      end
      if (fetch_acc) fetch_ptr <= fetch_warp_id;
      pending <= pending_nxt;
    end
  end

endmodule
